credit_link: RTL and testbench
==============================

Name: credit_link

Overview:
- Parametrised successor to the fixed-delay inter-node link used six times per node.
- Models one direction of an MGT link between two node switches: a configurable-latency forward data pipe, a receive FIFO at the far end, and credit-based backpressure returned over a delayed credit pipe.
- Adds a windowed utilisation counter.
- Replaces the ready-bit-only handshake and makes the link lossless for any LinkDelay/FIFO sizing.

Parameters:
- DataWidth, 256, flit width in bits.
- LinkDelay, 20, forward pipe stages; legal range is 1 or more.
- CreditDelay, 20, credit return pipe stages; legal range is 1 or more.
- RxFIFODepth, 64, receive FIFO entries; must be a power of 2 and at least 2. This is also the initial credit count.
- UtilWindowLog2, 8, utilisation window is 2^UtilWindowLog2 cycles; must be 8 or more.

Ports:
- clk  in  1  single clock for both ends.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  DataWidth  flit from the upstream switch eject port.
- tx_valid  in  1  upstream offers a flit.
- tx_ready  out  1  a credit is available; a flit is accepted when tx_valid && tx_ready.
- rx_data  out  DataWidth  head of the receive FIFO (show-ahead).
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  downstream switch inject port consumes the head.
- credit_count  out  $clog2(RxFIFODepth+1)  current credits held by the transmitter.
- link_util  out  8  accepted flits in the last completed window, scaled.
- link_err  out  1  sticky; set if a FIFO write hits a full FIFO.

Behaviour:
- Reset (rst=0, async):
  - credit_count=RxFIFODepth, so tx_ready=1.
  - Both pipes are cleared (all valid bits 0); rx_data=0.
  - FIFO is empty, so rx_valid=0.
  - link_util=0, link_err=0, window counter=0.
  - Reset mid-flight discards every in-flight flit and credit. No flit may appear after deassertion unless it is accepted after deassertion.
- Transmit:
  - tx_ready = (credit_count != 0), combinational from a register.
  - On accept, the flit and valid=1 enter stage 0 of the forward pipe. Otherwise valid=0 enters.
  - Accept decrements credit_count.
- Forward pipe:
  - LinkDelay register stages with no stall.
  - The output of the last stage writes the FIFO when valid.
- Latency:
  - A flit accepted in cycle t, with the FIFO empty, is visible with rx_valid=1 in cycle t+LinkDelay+1.
- FIFO:
  - Pop occurs when rx_valid && rx_ready. Simultaneous push and pop is allowed at any occupancy, including full: the pop frees the slot.
  - Pointers wrap modulo RxFIFODepth. Occupancy uses one extra bit.
  - Push to a full FIFO without a pop drops the flit and sets link_err. This is unreachable by construction and is checked in verification.
- Credit return:
  - Each pop injects a credit (valid=1) into stage 0 of the CreditDelay-stage pipe.
  - A credit leaving the last stage increments credit_count, so a pop in cycle p raises credit_count in cycle p+CreditDelay+1.
- Credit arithmetic:
  - Accept and credit arrival in the same cycle leave credit_count unchanged.
  - credit_count never exceeds RxFIFODepth and never underflows.
  - Full throughput requires RxFIFODepth >= LinkDelay+CreditDelay+2. Below that, throughput degrades gracefully with no loss.
- Utilisation:
  - An UtilWindowLog2-bit cycle counter free-runs, and an accept counter increments on each accept.
  - At window wrap (cycle counter all ones):
    - link_util = min(255, (acc + this-cycle accept) >> (UtilWindowLog2-8)).
    - The accept counter is cleared.
  - link_util holds its value between updates.

Decomposition:
- Shared package (link_pkg):
  - UTIL_WIDTH=8.
  - The function clog2 for counter widths.
  - A flit_t typedef parametrised by DataWidth, where the tool allows.
- Sub-module link_delay_line (params Width, Depth; ports clk, rst, in_valid, in_data, out_valid, out_data):
  - Instantiated twice: forward pipe with Width=DataWidth, and credit pipe with Width=0/valid only.
- FIFO and credit/util logic stay inline in credit_link.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release.
  - Required: credit_count=64, tx_ready=1, rx_valid=0, link_util=0, link_err=0.
- Single flit: accept tx_data=256'hA5 in cycle 10 with rx_ready=0.
  - Required: rx_valid rises in cycle 31 with rx_data=A5; credit_count=63 from cycle 11.
- Streaming: tx_valid=1 and rx_ready=1 for 1000 cycles (depth 64, delays 20/20).
  - Required: tx_ready never drops; 1000 flits arrive in order; link_util=255 at the first window end after 256 accepts.
- Backpressure: rx_ready=0, tx_valid=1 continuously.
  - Required: exactly 64 accepts, then tx_ready=0 with credit_count=0; no loss; link_err=0.
  - Then set rx_ready=1 at cycle p.
  - Required: credit_count becomes 1 at p+21, and flits resume in order.
- Small FIFO: RxFIFODepth=4, streaming.
  - Required: sustained throughput 4/(20+20+2) per cycle, all flits delivered, link_err=0.
- Reset mid-flight: assert rst with 10 flits in the pipe and 5 in the FIFO.
  - Required: after release, rx_valid stays 0 for 50 cycles with no input, and credit_count=64.

Source files
------------

// File: rtl/link_pkg.sv
// Shared constants and helpers for the credit-based inter-node link.
package link_pkg;

  localparam int UTIL_WIDTH = 8;

  // Ceiling log2, used to size pointers and counters from parameters.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/link_delay_line.sv
// Fixed-latency, non-stalling valid/data pipe. Width=0 builds a valid-only pipe.
module link_delay_line #(
  parameter int Width = 1,
  parameter int Depth = 1,
  localparam int DW   = (Width > 0) ? Width : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [Depth-1:0] valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < Depth; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  assign out_valid = valid_q[Depth-1];

  if (Width > 0) begin : g_data
    logic [DW-1:0] data_q [Depth];

    // NOTE: data stages carry no reset; valid_q alone qualifies them, and
    // leaving wide storage unreset keeps it out of the reset tree.
    always_ff @(posedge clk) begin
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < Depth; i++) begin
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end

    assign out_data = data_q[Depth-1];
  end else begin : g_no_data
    logic in_data_unused;
    assign in_data_unused = ^in_data;
    assign out_data       = '0;
  end

endmodule

// File: rtl/credit_link.sv
// One direction of a lossless credit-flow-controlled link: forward pipe,
// far-end receive FIFO, delayed credit return and a windowed utilisation meter.
module credit_link
  import link_pkg::*;
#(
  parameter int DataWidth      = 256,
  parameter int LinkDelay      = 20,
  parameter int CreditDelay    = 20,
  parameter int RxFIFODepth    = 64,
  parameter int UtilWindowLog2 = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DataWidth-1:0]                tx_data,
  input  logic                                tx_valid,
  output logic                                tx_ready,
  output logic [DataWidth-1:0]                rx_data,
  output logic                                rx_valid,
  input  logic                                rx_ready,
  output logic [clog2(RxFIFODepth+1)-1:0]     credit_count,
  output logic [UTIL_WIDTH-1:0]               link_util,
  output logic                                link_err
);

  localparam int AW = clog2(RxFIFODepth);
  localparam int CW = clog2(RxFIFODepth + 1);

  typedef logic [DataWidth-1:0] flit_t;

  logic  accept;
  logic  fwd_valid;
  flit_t fwd_data;
  logic  pop;
  logic  push;
  logic  full;
  logic  credit_arrive;
  logic  credit_data_unused;

  assign tx_ready = (credit_count != '0);
  assign accept   = tx_valid && tx_ready;

  link_delay_line #(.Width(DataWidth), .Depth(LinkDelay)) u_fwd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  (tx_data),
    .out_valid(fwd_valid),
    .out_data (fwd_data)
  );

  // Receive FIFO: pointers carry one wrap bit so full and empty are distinct.
  flit_t         mem [RxFIFODepth];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign rx_valid = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rx_valid && rx_ready;
  assign push     = fwd_valid && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= fwd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      link_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (fwd_valid && full && !pop) link_err <= 1'b1;
    end
  end

  link_delay_line #(.Width(0), .Depth(CreditDelay)) u_credit_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (pop),
    .in_data  (1'b0),
    .out_valid(credit_arrive),
    .out_data (credit_data_unused)
  );

  // An accept and a returning credit in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_count <= CW'(RxFIFODepth);
    end else if (accept && !credit_arrive) begin
      credit_count <= credit_count - CW'(1);
    end else if (!accept && credit_arrive) begin
      credit_count <= credit_count + CW'(1);
    end
  end

  logic [UtilWindowLog2-1:0] win_cnt;
  logic [UtilWindowLog2:0]   acc_cnt;
  logic [UtilWindowLog2:0]   acc_total;
  logic [UtilWindowLog2:0]   acc_scaled;
  logic [UTIL_WIDTH-1:0]     util_next;
  logic                      win_wrap;

  assign win_wrap   = &win_cnt;
  assign acc_total  = acc_cnt + {{UtilWindowLog2{1'b0}}, accept};
  assign acc_scaled = acc_total >> (UtilWindowLog2 - UTIL_WIDTH);
  assign util_next  = (|acc_scaled[UtilWindowLog2:UTIL_WIDTH]) ? '1
                                                               : acc_scaled[UTIL_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt   <= '0;
      acc_cnt   <= '0;
      link_util <= '0;
    end else begin
      win_cnt <= win_cnt + UtilWindowLog2'(1);
      if (win_wrap) begin
        link_util <= util_next;
        acc_cnt   <= '0;
      end else begin
        acc_cnt   <= acc_total;
      end
    end
  end

endmodule

// File: tb/tb_credit_link.sv
// Self-checking bench for credit_link: event-scheduled queue model, phase
// table, directed latency/backpressure/reset sequences and a small-FIFO instance.
module tb_credit_link;

  localparam int DW    = 256;
  localparam int LD    = 20;
  localparam int CD    = 20;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [6:0]    credit_count;
  logic [7:0]    link_util;
  logic          link_err;

  logic [DW-1:0] tx_data2 = '0;
  logic          tx_valid2 = 1'b0;
  logic          tx_ready2;
  logic [DW-1:0] rx_data2;
  logic          rx_valid2;
  logic          rx_ready2 = 1'b0;
  logic [2:0]    credit_count2;
  logic [7:0]    link_util2;
  logic          link_err2;

  always #5 clk = ~clk;

  credit_link #(.DataWidth(DW), .LinkDelay(LD), .CreditDelay(CD),
                .RxFIFODepth(DEPTH), .UtilWindowLog2(8)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .credit_count(credit_count), .link_util(link_util), .link_err(link_err)
  );

  credit_link #(.DataWidth(DW), .LinkDelay(LD), .CreditDelay(CD),
                .RxFIFODepth(4), .UtilWindowLog2(8)) dut_small (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .credit_count(credit_count2), .link_util(link_util2), .link_err(link_err2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: flits and credits are scheduled by arrival cycle.
  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } flight_t;

  flight_t       flight[$];
  int            cred_due[$];
  logic [DW-1:0] fifo_m[$];
  int            credits_m;
  int            cyc;
  int            win_acc;
  int            util_m;
  bit            err_m;
  bit            obs_acc;
  bit            obs_pop;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    flight.delete();
    cred_due.delete();
    fifo_m.delete();
    credits_m = DEPTH;
    cyc       = 0;
    win_acc   = 0;
    util_m    = 0;
    err_m     = 1'b0;
  endtask

  task automatic model_update(input bit tv, input bit rr, input logic [DW-1:0] d);
    bit a;
    bit p;
    a = tv && (credits_m > 0);
    p = (fifo_m.size() > 0) && rr;
    if (a) begin
      flight.push_back('{d, cyc + LD + 1});
      credits_m--;
      win_acc++;
    end
    if (p) begin
      void'(fifo_m.pop_front());
      cred_due.push_back(cyc + CD + 1);
    end
    if (cyc % 256 == 255) begin
      util_m  = (win_acc > 255) ? 255 : win_acc;
      win_acc = 0;
    end
    cyc++;
    while (flight.size() > 0 && flight[0].due == cyc) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back(flight[0].d);
      else err_m = 1'b1;
      void'(flight.pop_front());
    end
    while (cred_due.size() > 0 && cred_due[0] == cyc) begin
      credits_m++;
      void'(cred_due.pop_front());
    end
  endtask

  task automatic compare_model();
    check("tx_ready", tx_ready, credits_m != 0);
    check("credit_count", credit_count, credits_m);
    check("rx_valid", rx_valid, fifo_m.size() != 0);
    if (fifo_m.size() != 0) check("rx_data", rx_data, fifo_m[0]);
    check("link_util", link_util, util_m);
    check("link_err", link_err, err_m);
  endtask

  // Called at a falling edge: compare, drive for the next rising edge, advance.
  task automatic step(input bit tv, input bit rr, input logic [DW-1:0] d);
    compare_model();
    tx_valid = tv;
    rx_ready = rr;
    tx_data  = d;
    obs_acc  = tv && tx_ready;
    obs_pop  = rx_valid && rr;
    model_update(tv, rr, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    tx_valid2 = 1'b0;
    rx_ready2 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    string name;
    int    cycles;
    bit    tv;
    bit    rr;
    int    exp_credit;
    bit    exp_rx_valid;
    bit    exp_tx_ready;
  } phase_t;

  phase_t        tbl[5];
  int            seq;
  int            acc_cnt;
  int            pop_cnt;
  int            p;
  int            ptv;
  int            prr;
  logic [DW-1:0] rnd;
  int            seq2;
  int            exp2;
  int            win2;
  int            acc2;
  int            pop2;

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_credit", credit_count, 64);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_link_util", link_util, 0);
    check("reset_link_err", link_err, 0);

    // Single flit latency.
    for (int i = 0; i < 10; i++) step(0, 0, '0);
    step(1, 0, 256'hA5);
    while (cyc <= 40) begin
      if (cyc == 11) check("single_credit_63", credit_count, 63);
      if (cyc == 30) check("single_not_yet", rx_valid, 0);
      if (cyc == 31) begin
        check("single_arrive", rx_valid, 1);
        check("single_data", rx_data, 256'hA5);
      end
      step(0, 0, '0);
    end
    for (int i = 0; i < 30; i++) step(0, 1, '0);

    // Phase table.
    tbl[0] = '{"idle",       5,   1'b0, 1'b0, 64, 1'b0, 1'b1};
    tbl[1] = '{"fill",       64,  1'b1, 1'b0, 0,  1'b1, 1'b0};
    tbl[2] = '{"stall",      30,  1'b1, 1'b0, 0,  1'b1, 1'b0};
    tbl[3] = '{"drain",      100, 1'b0, 1'b1, 64, 1'b0, 1'b1};
    tbl[4] = '{"stream",     50,  1'b1, 1'b1, 23, 1'b1, 1'b1};
    do_reset();
    seq = 1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < tbl[k].cycles; i++) begin
        step(tbl[k].tv, tbl[k].rr, DW'(seq));
        seq++;
      end
      check({tbl[k].name, "_credit"}, credit_count, tbl[k].exp_credit);
      check({tbl[k].name, "_rx_valid"}, rx_valid, tbl[k].exp_rx_valid);
      check({tbl[k].name, "_tx_ready"}, tx_ready, tbl[k].exp_tx_ready);
    end

    // Streaming 1000 flits.
    do_reset();
    acc_cnt = 0;
    pop_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc == 256) check("stream_util_255", link_util, 255);
      step(1, 1, DW'(i + 1000));
      acc_cnt += int'(obs_acc);
      pop_cnt += int'(obs_pop);
    end
    for (int i = 0; i < 60; i++) begin
      step(0, 1, '0);
      pop_cnt += int'(obs_pop);
    end
    check("stream_accepts", acc_cnt, 1000);
    check("stream_delivered", pop_cnt, 1000);

    // Backpressure then release.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, DW'(i + 5000));
      acc_cnt += int'(obs_acc);
    end
    check("bp_accepts", acc_cnt, 64);
    check("bp_credit_0", credit_count, 0);
    check("bp_tx_ready_0", tx_ready, 0);
    check("bp_link_err", link_err, 0);
    p = cyc;
    for (int i = 0; i < 120; i++) begin
      if (cyc == p + 20) check("bp_credit_p20", credit_count, 0);
      if (cyc == p + 21) check("bp_credit_p21", credit_count, 1);
      step(1, 1, DW'(i + 6000));
    end

    // Randomised traffic.
    do_reset();
    ptv = 50;
    prr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        ptv = $urandom_range(10, 100);
        prr = $urandom_range(10, 100);
      end
      rnd = {8{$urandom()}};
      step($urandom_range(1, 100) <= ptv, $urandom_range(1, 100) <= prr, rnd);
    end

    // Reset with 10 flits in the pipe and 5 in the FIFO.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 0, DW'(i + 9000));
    for (int i = 0; i < 10; i++) step(0, 0, '0);
    do_reset();
    for (int i = 0; i < 50; i++) begin
      check("midrst_rx_valid", rx_valid, 0);
      step(0, 1, '0);
    end
    check("midrst_credit", credit_count, 64);

    // Small FIFO throughput.
    do_reset();
    seq2 = 0;
    exp2 = 0;
    win2 = 0;
    acc2 = 0;
    pop2 = 0;
    for (int i = 0; i < 960; i++) begin
      tx_valid2 = (i < 900);
      rx_ready2 = 1'b1;
      tx_data2  = DW'(seq2);
      if (rx_valid2) begin
        check("small_order", rx_data2, DW'(exp2));
        exp2++;
        pop2++;
      end
      if (tx_valid2 && tx_ready2) begin
        seq2++;
        acc2++;
        if (i >= 420 && i < 840) win2++;
      end
      step(0, 1, '0);
    end
    check("small_throughput", win2, 40);
    check("small_delivered", pop2, acc2);
    check("small_link_err", link_err2, 0);
    check("small_credit", credit_count2, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
